// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e : receive/transmit frame FSM states
//   PAR_NONE / PAR_EVEN / PAR_ODD : encodings for the PARITY_MODE parameter
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-flop synchronizer for the serial line plus the bit-value sampler.
//   clk, rst  : system clock, asynchronous active-high reset
//   baudTick  : oversample enable (present only when UART_RX_MAJORITY_EN is defined)
//   rx        : asynchronous serial input, idle high
//   rxS       : synchronized line
//   sample    : bit value to use on the current oversample tick
// Build option UART_RX_MAJORITY_EN: sample is the 2-of-3 majority of rxS over the current
// and two previous baudTicks; otherwise sample is rxS itself.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
`ifdef UART_RX_MAJORITY_EN
    input  logic baudTick,
`endif
    input  logic rx,
    output logic rxS,
    output logic sample
);

    logic rx_meta_q;
    logic rx_sync_q;

    // Reset to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rxS = rx_sync_q;

`ifdef UART_RX_MAJORITY_EN
    // Holds rxS from the two previous baudTicks; the live rxS is the third vote.
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else if (baudTick) begin
            hist_q <= {hist_q[0], rx_sync_q};
        end
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync_q) | (hist_q[0] & rx_sync_q);
`else
    assign sample = rx_sync_q;
`endif

endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: parametrised UART receive engine with framing/parity/overrun/break status
// and a held output register with read handshake.
//   clk, rst   : system clock, asynchronous active-high reset
//   baudTick   : one-cycle oversample enable (OVERSAMPLE pulses per bit)
//   rx         : serial line, idle high
//   dataRead   : consumer acknowledge, clears dataValid
//   ready      : FSM idle and armed for a new start bit
//   dataOut    : last completed frame's data, held until the next completed frame
//   dataValid  : dataOut holds an unread value
//   newByte    : one-cycle pulse on the start-confirming baudTick
//   frameErr, parityErr, breakDet, overrun : status of the frame in dataOut
// Build option UART_RX_MAJORITY_EN: 3-sample majority voting (see uart_rx_sampler).
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baudTick,
    input  logic                  rx,
    input  logic                  dataRead,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    output logic                  newByte,
    output logic                  frameErr,
    output logic                  parityErr,
    output logic                  breakDet,
    output logic                  overrun
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_WIDTH);

    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);
    localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

    logic rx_s;
    logic sample;

    uart_rx_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
`ifdef UART_RX_MAJORITY_EN
        .baudTick (baudTick),
`endif
        .rx       (rx),
        .rxS      (rx_s),
        .sample   (sample)
    );

    uart_state_e           state_q;
    logic [TickW-1:0]      tick_q;
    logic [BitW-1:0]       bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  armed_q;
    logic                  par_bit_q;
    logic                  par_err_q;
    logic                  frm_err_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;
    logic                  frame_err_q;
    logic                  parity_err_q;
    logic                  break_det_q;
    logic                  overrun_q;

    logic stop_fe;
    logic odd_sel;

    // Frame error including the stop sample being taken this tick.
    assign stop_fe = frm_err_q | ~sample;
    assign odd_sel = (PARITY_MODE == PAR_ODD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            armed_q      <= 1'b1;
            par_bit_q    <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (dataRead && data_valid_q) begin
                data_valid_q <= 1'b0;
            end
            if (baudTick) begin
                unique case (state_q)
                    StIdle: begin
                        tick_q <= '0;
                        bit_q  <= '0;
                        if (rx_s) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q <= StStart;
                        end
                    end
                    StStart: begin
                        if (tick_q == TickHalf) begin
                            tick_q    <= '0;
                            bit_q     <= '0;
                            par_bit_q <= 1'b0;
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                            // A high sample here was a glitch: drop back without touching status.
                            state_q   <= sample ? StIdle : StData;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    StData: begin
                        if (tick_q == TickLast) begin
                            tick_q  <= '0;
                            // LSB arrives first, so shift in from the top.
                            shift_q <= {sample, shift_q[DATA_WIDTH-1:1]};
                            if (bit_q == BitLast) begin
                                bit_q   <= '0;
                                state_q <= (PARITY_MODE != PAR_NONE) ? StParity : StStop;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    StParity: begin
                        if (tick_q == TickLast) begin
                            tick_q    <= '0;
                            bit_q     <= '0;
                            par_bit_q <= sample;
                            par_err_q <= sample != ((^shift_q) ^ odd_sel);
                            state_q   <= StStop;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    StStop: begin
                        if (tick_q == TickLast) begin
                            tick_q    <= '0;
                            frm_err_q <= stop_fe;
                            if (bit_q == StopLast) begin
                                bit_q        <= '0;
                                state_q      <= StIdle;
                                data_out_q   <= shift_q;
                                frame_err_q  <= stop_fe;
                                parity_err_q <= par_err_q;
                                break_det_q  <= stop_fe && (shift_q == '0) &&
                                                ((PARITY_MODE == PAR_NONE) || !par_bit_q);
                                // A read in the commit cycle consumed the old value in time.
                                overrun_q    <= data_valid_q && !dataRead;
                                data_valid_q <= 1'b1;
                                // Stay disarmed until the line is seen idle again.
                                if (stop_fe) begin
                                    armed_q <= 1'b0;
                                end
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign newByte   = baudTick && (state_q == StStart) && (tick_q == TickHalf) && !sample;
    assign ready     = (state_q == StIdle) && armed_q;
    assign dataOut   = data_out_q;
    assign dataValid = data_valid_q;
    assign frameErr  = frame_err_q;
    assign parityErr = parity_err_q;
    assign breakDet  = break_det_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
module tb_uart_rx_framed;

    localparam int BIT_CLKS = 64;  // 16 baudTicks x 4 clocks

    logic       clk;
    logic       rst;
    logic       baudTick;
    logic       rx;
    logic       dataRead;
    logic       ready;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       newByte;
    logic       frameErr;
    logic       parityErr;
    logic       breakDet;
    logic       overrun;

    logic       p_rx;
    logic       p_dataRead;
    logic       p_ready;
    logic [7:0] p_dataOut;
    logic       p_dataValid;
    logic       p_newByte;
    logic       p_frameErr;
    logic       p_parityErr;
    logic       p_breakDet;
    logic       p_overrun;

    int n_checks;
    int n_pass;
    int nb_cnt;
    int nb_base;
    int cyc;
    int ticks;
    bit seen;

    uart_rx_framed u_dut (
        .clk       (clk),
        .rst       (rst),
        .baudTick  (baudTick),
        .rx        (rx),
        .dataRead  (dataRead),
        .ready     (ready),
        .dataOut   (dataOut),
        .dataValid (dataValid),
        .newByte   (newByte),
        .frameErr  (frameErr),
        .parityErr (parityErr),
        .breakDet  (breakDet),
        .overrun   (overrun)
    );

    uart_rx_framed #(
        .PARITY_MODE (1)
    ) u_par (
        .clk       (clk),
        .rst       (rst),
        .baudTick  (baudTick),
        .rx        (p_rx),
        .dataRead  (p_dataRead),
        .ready     (p_ready),
        .dataOut   (p_dataOut),
        .dataValid (p_dataValid),
        .newByte   (p_newByte),
        .frameErr  (p_frameErr),
        .parityErr (p_parityErr),
        .breakDet  (p_breakDet),
        .overrun   (p_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baudTick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baudTick = 1'b1;
            @(negedge clk);
            baudTick = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (newByte) nb_cnt <= nb_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive n bits LSB first, one bit period each, on the plain or the parity line.
    task automatic send_bits(input bit par_line, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (par_line) p_rx = bits[i];
            else rx = bits[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic read_pulse(input bit par_line);
        @(negedge clk);
        if (par_line) p_dataRead = 1'b1;
        else dataRead = 1'b1;
        @(negedge clk);
        p_dataRead = 1'b0;
        dataRead   = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        nb_cnt     = 0;
        rst        = 1'b1;
        rx         = 1'b1;
        p_rx       = 1'b1;
        dataRead   = 1'b0;
        p_dataRead = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", ready, 1);
        check("rst_dataOut", dataOut, 0);
        check("rst_dataValid", dataValid, 0);
        check("rst_newByte", newByte, 0);
        check("rst_flags", {frameErr, parityErr, breakDet, overrun}, 0);
        repeat (BIT_CLKS) @(negedge clk);

        // Clean 0xA5 frame
        nb_base = nb_cnt;
        send_bits(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
        repeat (BIT_CLKS) @(negedge clk);
        check("a5_dataOut", dataOut, 8'hA5);
        check("a5_dataValid", dataValid, 1);
        check("a5_flags", {frameErr, parityErr, breakDet, overrun}, 0);
        check("a5_newByte_once", nb_cnt - nb_base, 1);
        check("a5_ready", ready, 1);
        read_pulse(0);
        check("a5_read_clears", dataValid, 0);

        // Even parity, 0x3C: wrong then correct parity bit
        send_bits(1, {5'h1f, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        repeat (BIT_CLKS) @(negedge clk);
        check("par_bad_dataOut", p_dataOut, 8'h3C);
        check("par_bad_parityErr", p_parityErr, 1);
        check("par_bad_frameErr", p_frameErr, 0);
        read_pulse(1);
        send_bits(1, {5'h1f, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        repeat (BIT_CLKS) @(negedge clk);
        check("par_ok_parityErr", p_parityErr, 0);
        check("par_ok_dataValid", p_dataValid, 1);
        check("par_ok_overrun", p_overrun, 0);

        // Stop bit forced low on 0x55
        send_bits(0, {6'h00, 1'b0, 8'h55, 1'b0}, 10);
        check("fe_frameErr", frameErr, 1);
        check("fe_dataOut", dataOut, 8'h55);
        check("fe_breakDet", breakDet, 0);
        check("fe_ready_low", ready, 0);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("fe_ready_back", ready, 1);
        read_pulse(0);

        // Break: line low for 12 bit periods
        nb_base = nb_cnt;
        send_bits(0, 16'h0000, 12);
        check("brk_breakDet", breakDet, 1);
        check("brk_frameErr", frameErr, 1);
        check("brk_dataOut", dataOut, 0);
        check("brk_ready_low", ready, 0);
        check("brk_one_frame", nb_cnt - nb_base, 1);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("brk_ready_back", ready, 1);
        check("brk_no_new_frame", nb_cnt - nb_base, 1);
        read_pulse(0);

        // Overrun: two frames without a read
        send_bits(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10);
        repeat (BIT_CLKS) @(negedge clk);
        check("ovr_first_overrun", overrun, 0);
        send_bits(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10);
        repeat (BIT_CLKS) @(negedge clk);
        check("ovr_dataOut", dataOut, 8'h22);
        check("ovr_overrun", overrun, 1);
        check("ovr_dataValid", dataValid, 1);

        // Read in the commit cycle: 144th baudTick after the start-confirm tick
        fork
            send_bits(0, {6'h3f, 1'b1, 8'h33, 1'b0}, 10);
            begin
                cyc   = 0;
                ticks = 0;
                seen  = 1'b0;
                while (!seen && cyc < 2000) begin
                    @(negedge clk);
                    #1;
                    cyc++;
                    if (newByte) seen = 1'b1;
                end
                check("cr_newByte_seen", {31'd0, seen}, 1);
                while (seen && ticks < 144) begin
                    @(negedge clk);
                    #1;
                    if (baudTick) ticks++;
                end
                dataRead = 1'b1;
                @(negedge clk);
                dataRead = 1'b0;
            end
        join
        repeat (BIT_CLKS) @(negedge clk);
        check("cr_dataOut", dataOut, 8'h33);
        check("cr_dataValid", dataValid, 1);
        check("cr_overrun", overrun, 0);
        read_pulse(0);

        // 3-tick glitch in idle
        nb_base = nb_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("gl_no_newByte", nb_cnt - nb_base, 0);
        check("gl_no_dataValid", dataValid, 0);
        check("gl_ready", ready, 1);

        // Leave status non-zero, then reset mid-DATA
        send_bits(0, {6'h00, 1'b0, 8'h0F, 1'b0}, 10);
        check("pre_rst_frameErr", frameErr, 1);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        fork
            send_bits(0, {6'h3f, 1'b1, 8'h5A, 1'b0}, 10);
            begin
                repeat (3 * BIT_CLKS) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("mid_rst_dataOut", dataOut, 0);
                check("mid_rst_dataValid", dataValid, 0);
                check("mid_rst_flags", {frameErr, parityErr, breakDet, overrun}, 0);
                check("mid_rst_ready", ready, 1);
                check("mid_rst_newByte", newByte, 0);
            end
        join
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
